// File: rtl/yarp_rf_wb_ctrl.sv
// Writeback controller for the register file write port: round-robin EX/LSU
// arbitration, one-cycle write stage, pending-load scoreboard and load credit limit.
module yarp_rf_wb_ctrl #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_vld_i,
    input  logic [4:0]  issue_rd_i,
    output logic        issue_rdy_o,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    output logic        rs1_busy_o,
    output logic        rs2_busy_o,
    input  logic        ex_vld_i,
    input  logic [4:0]  ex_rd_i,
    input  logic [31:0] ex_data_i,
    output logic        ex_rdy_o,
    input  logic        lsu_vld_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_rdy_o,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_rd_addr_o,
    output logic [31:0] rf_wr_data_o,
    output logic        err_o
);

    typedef enum logic {
        GRANT_EX  = 1'b0,
        GRANT_LSU = 1'b1
    } grant_t;

    grant_t           last_grant;
    logic [31:0]      scoreboard;
    logic [CNT_W-1:0] out_cnt;
    logic             wr_from_lsu;

    logic             ex_go;
    logic             lsu_go;
    logic             issue_go;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic             err_set;

    // On contention the requester that did not win last time gets the port.
    assign ex_rdy_o  = ex_vld_i  & (~lsu_vld_i | (last_grant == GRANT_LSU));
    assign lsu_rdy_o = lsu_vld_i & (~ex_vld_i  | (last_grant == GRANT_EX));

    assign issue_rdy_o = (out_cnt < CNT_W'(MAX_OUT));
    assign rs1_busy_o  = scoreboard[rs1_addr_i];
    assign rs2_busy_o  = scoreboard[rs2_addr_i];

    assign ex_go    = ex_vld_i & ex_rdy_o;
    assign lsu_go   = lsu_vld_i & lsu_rdy_o;
    assign issue_go = issue_vld_i & issue_rdy_o;

    // A pending bit drops only once its load data is actually on the write port,
    // so decode never sees the register as free before the file holds the value.
    always_comb begin
        set_mask = 32'd0;
        clr_mask = 32'd0;
        if (issue_go && (issue_rd_i != 5'd0))
            set_mask = 32'd1 << issue_rd_i;
        if (wr_from_lsu)
            clr_mask = 32'd1 << rf_rd_addr_o;
    end

    assign err_set = (issue_go && (issue_rd_i != 5'd0) && scoreboard[issue_rd_i])
                   || (lsu_go && (out_cnt == '0))
                   || (lsu_go && (lsu_rd_i != 5'd0) && !scoreboard[lsu_rd_i]);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant   <= GRANT_EX;
            scoreboard   <= 32'd0;
            out_cnt      <= '0;
            wr_from_lsu  <= 1'b0;
            rf_wr_en_o   <= 1'b0;
            rf_rd_addr_o <= 5'd0;
            rf_wr_data_o <= 32'd0;
            err_o        <= 1'b0;
        end else begin
            if (ex_go || lsu_go) begin
                last_grant   <= lsu_go ? GRANT_LSU : GRANT_EX;
                rf_rd_addr_o <= lsu_go ? lsu_rd_i : ex_rd_i;
                rf_wr_data_o <= lsu_go ? lsu_data_i : ex_data_i;
                rf_wr_en_o   <= lsu_go ? (lsu_rd_i != 5'd0) : (ex_rd_i != 5'd0);
                wr_from_lsu  <= lsu_go && (lsu_rd_i != 5'd0);
            end else begin
                rf_wr_en_o  <= 1'b0;
                wr_from_lsu <= 1'b0;
            end

            scoreboard <= ((scoreboard & ~clr_mask) | set_mask) & ~32'd1;

            // An unmatched LSU response is flagged as an error and the count floors at zero.
            if (issue_go && !lsu_go)
                out_cnt <= out_cnt + 1'b1;
            else if (lsu_go && !issue_go && (out_cnt != '0))
                out_cnt <= out_cnt - 1'b1;

            if (err_set)
                err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_yarp_rf_wb_ctrl.sv
// Directed and randomized bench for yarp_rf_wb_ctrl, checked every cycle against a
// behavioural model built from pending-register sets and an outstanding-load tally.
module tb_yarp_rf_wb_ctrl;

    localparam int MAX_OUT = 4;

    logic        clk;
    logic        reset;
    logic        issue_vld;
    logic [4:0]  issue_rd;
    logic        issue_rdy;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        ex_vld;
    logic [4:0]  ex_rd;
    logic [31:0] ex_data;
    logic        ex_rdy;
    logic        lsu_vld;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_rdy;
    logic        rf_wr_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_wr_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit          pend[32];
    int          m_out;
    bit          m_last_lsu;
    bit          m_err;
    bit          m_wr_en;
    bit [4:0]    m_addr;
    bit [31:0]   m_data;
    bit          m_wr_lsu;
    bit          m_gex;
    bit          m_glsu;

    yarp_rf_wb_ctrl #(.MAX_OUT(MAX_OUT), .CNT_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .issue_vld_i  (issue_vld),
        .issue_rd_i   (issue_rd),
        .issue_rdy_o  (issue_rdy),
        .rs1_addr_i   (rs1_addr),
        .rs2_addr_i   (rs2_addr),
        .rs1_busy_o   (rs1_busy),
        .rs2_busy_o   (rs2_busy),
        .ex_vld_i     (ex_vld),
        .ex_rd_i      (ex_rd),
        .ex_data_i    (ex_data),
        .ex_rdy_o     (ex_rdy),
        .lsu_vld_i    (lsu_vld),
        .lsu_rd_i     (lsu_rd),
        .lsu_data_i   (lsu_data),
        .lsu_rdy_o    (lsu_rdy),
        .rf_wr_en_o   (rf_wr_en),
        .rf_rd_addr_o (rf_rd_addr),
        .rf_wr_data_o (rf_wr_data),
        .err_o        (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Who wins the port: a lone requester always, otherwise whoever lost last time.
    function automatic bit exp_ex_grant();
        if (!ex_vld) return 1'b0;
        if (!lsu_vld) return 1'b1;
        return m_last_lsu;
    endfunction

    function automatic bit exp_lsu_grant();
        if (!lsu_vld) return 1'b0;
        if (!ex_vld) return 1'b1;
        return !m_last_lsu;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) pend[i] = 1'b0;
        m_out      = 0;
        m_last_lsu = 1'b0;
        m_err      = 1'b0;
        m_wr_en    = 1'b0;
        m_addr     = 5'd0;
        m_data     = 32'd0;
        m_wr_lsu   = 1'b0;
        m_gex      = 1'b0;
        m_glsu     = 1'b0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle.
    task automatic model_step();
        bit gex, glsu, igo;
        if (reset) begin
            model_reset();
            return;
        end
        gex  = exp_ex_grant();
        glsu = exp_lsu_grant();
        igo  = issue_vld && (m_out < MAX_OUT);
        if (igo && issue_rd != 0 && pend[issue_rd]) m_err = 1'b1;
        if (glsu && m_out == 0) m_err = 1'b1;
        if (glsu && lsu_rd != 0 && !pend[lsu_rd]) m_err = 1'b1;
        if (m_wr_en && m_wr_lsu) pend[m_addr] = 1'b0;
        if (igo && issue_rd != 0) pend[issue_rd] = 1'b1;
        m_out = m_out + (igo ? 1 : 0) - (glsu ? 1 : 0);
        if (m_out < 0) m_out = 0;
        if (gex || glsu) begin
            m_addr     = glsu ? lsu_rd : ex_rd;
            m_data     = glsu ? lsu_data : ex_data;
            m_wr_en    = (m_addr != 0);
            m_wr_lsu   = glsu;
            m_last_lsu = glsu;
        end else begin
            m_wr_en  = 1'b0;
            m_wr_lsu = 1'b0;
        end
        m_gex  = gex;
        m_glsu = glsu;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Let combinational outputs settle, then compare every output with the model.
    task automatic applyStimulus();
        #1;
        checkOutput("ex_rdy",     32'(ex_rdy),     32'(exp_ex_grant()));
        checkOutput("lsu_rdy",    32'(lsu_rdy),    32'(exp_lsu_grant()));
        checkOutput("issue_rdy",  32'(issue_rdy),  32'(m_out < MAX_OUT));
        checkOutput("rs1_busy",   32'(rs1_busy),   32'(pend[rs1_addr]));
        checkOutput("rs2_busy",   32'(rs2_busy),   32'(pend[rs2_addr]));
        checkOutput("rf_wr_en",   32'(rf_wr_en),   32'(m_wr_en));
        checkOutput("rf_rd_addr", 32'(rf_rd_addr), 32'(m_addr));
        checkOutput("rf_wr_data", rf_wr_data,      m_data);
        checkOutput("err",        32'(err),        32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reset     = 1'b0;
        issue_vld = 1'b0;
        issue_rd  = 5'd0;
        ex_vld    = 1'b0;
        ex_rd     = 5'd0;
        ex_data   = 32'd0;
        lsu_vld   = 1'b0;
        lsu_rd    = 5'd0;
        lsu_data  = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        applyStimulus();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        reset    = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        applyStimulus();
        checkOutput("rst_issue_rdy", 32'(issue_rdy), 32'd1);
        checkOutput("rst_wr_en", 32'(rf_wr_en), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        tick();

        // Single EX write, one-cycle latency
        ex_vld = 1'b1; ex_rd = 5'd5; ex_data = 32'hDEADBEEF;
        applyStimulus();
        checkOutput("ex_single_rdy", 32'(ex_rdy), 32'd1);
        tick();
        ex_vld = 1'b0;
        applyStimulus();
        checkOutput("ex_single_en", 32'(rf_wr_en), 32'd1);
        checkOutput("ex_single_addr", 32'(rf_rd_addr), 32'd5);
        checkOutput("ex_single_data", rf_wr_data, 32'hDEADBEEF);
        tick();
        applyStimulus();
        checkOutput("ex_single_en_drop", 32'(rf_wr_en), 32'd0);
        tick();

        // Round-robin under continuous contention
        do_reset();
        ex_vld = 1'b1; ex_rd = 5'd1; ex_data = 32'h1111_0001;
        lsu_vld = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_0002;
        for (int i = 0; i < 4; i++) begin
            applyStimulus();
            checkOutput("rr_lsu_grant", 32'(lsu_rdy), 32'((i % 2) == 0));
            checkOutput("rr_ex_grant", 32'(ex_rdy), 32'((i % 2) == 1));
            if (i > 0) checkOutput("rr_addr", 32'(rf_rd_addr), ((i % 2) == 1) ? 32'd2 : 32'd1);
            tick();
        end
        ex_vld = 1'b0; lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("rr_addr_last", 32'(rf_rd_addr), 32'd1);
        tick();

        // Load-use scoreboard set/clear timing
        do_reset();
        rs1_addr = 5'd7;
        issue_vld = 1'b1; issue_rd = 5'd7;
        applyStimulus();
        tick();
        issue_vld = 1'b0;
        applyStimulus();
        checkOutput("sb_busy_set", 32'(rs1_busy), 32'd1);
        tick();
        lsu_vld = 1'b1; lsu_rd = 5'd7; lsu_data = 32'hCAFE0007;
        applyStimulus();
        checkOutput("sb_lsu_rdy", 32'(lsu_rdy), 32'd1);
        tick();
        lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("sb_busy_during_write", 32'(rs1_busy), 32'd1);
        checkOutput("sb_write_addr", 32'(rf_rd_addr), 32'd7);
        tick();
        applyStimulus();
        checkOutput("sb_busy_cleared", 32'(rs1_busy), 32'd0);
        checkOutput("sb_err", 32'(err), 32'd0);
        tick();

        // Outstanding-load limit
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            issue_vld = 1'b1; issue_rd = 5'(r);
            applyStimulus();
            tick();
        end
        issue_vld = 1'b1; issue_rd = 5'd9;
        lsu_vld = 1'b1; lsu_rd = 5'd1; lsu_data = 32'h0000_0101;
        applyStimulus();
        checkOutput("lim_full", 32'(issue_rdy), 32'd0);
        tick();
        issue_vld = 1'b0; lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("lim_freed", 32'(issue_rdy), 32'd1);
        tick();
        issue_vld = 1'b1; issue_rd = 5'd6;
        lsu_vld = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h0000_0202;
        applyStimulus();
        tick();
        issue_vld = 1'b0; lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("lim_both_hold", 32'(issue_rdy), 32'd1);
        tick();
        issue_vld = 1'b1; issue_rd = 5'd8;
        applyStimulus();
        tick();
        issue_vld = 1'b0;
        applyStimulus();
        checkOutput("lim_full_again", 32'(issue_rdy), 32'd0);
        tick();
        lsu_vld = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h0000_0303;
        applyStimulus();
        tick();
        lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("lim_reopen", 32'(issue_rdy), 32'd1);
        tick();

        // Register zero handling
        ex_vld = 1'b1; ex_rd = 5'd0; ex_data = 32'h0BAD_0000;
        applyStimulus();
        tick();
        ex_vld = 1'b0;
        issue_vld = 1'b1; issue_rd = 5'd0;
        applyStimulus();
        checkOutput("rd0_ex_no_write", 32'(rf_wr_en), 32'd0);
        tick();
        issue_vld = 1'b0; rs1_addr = 5'd0;
        lsu_vld = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h0000_0F0F;
        applyStimulus();
        checkOutput("rd0_no_busy", 32'(rs1_busy), 32'd0);
        tick();
        lsu_vld = 1'b0;
        applyStimulus();
        checkOutput("rd0_no_err", 32'(err), 32'd0);
        tick();

        // Sticky error, then reset mid-stream
        do_reset();
        lsu_vld = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0909;
        applyStimulus();
        tick();
        lsu_vld = 1'b0;
        ex_vld = 1'b1; ex_rd = 5'd3; ex_data = 32'h3333_3333;
        applyStimulus();
        checkOutput("err_set", 32'(err), 32'd1);
        tick();
        ex_vld = 1'b0;
        issue_vld = 1'b1; issue_rd = 5'd10; rs1_addr = 5'd10;
        applyStimulus();
        tick();
        issue_vld = 1'b0;
        applyStimulus();
        checkOutput("err_held", 32'(err), 32'd1);
        tick();
        ex_vld = 1'b1; ex_rd = 5'd4; ex_data = 32'h4444_4444;
        reset = 1'b1;
        applyStimulus();
        tick();
        idle_inputs();
        applyStimulus();
        checkOutput("rst_mid_err", 32'(err), 32'd0);
        checkOutput("rst_mid_busy", 32'(rs1_busy), 32'd0);
        checkOutput("rst_mid_issue_rdy", 32'(issue_rdy), 32'd1);
        checkOutput("rst_mid_wr_en", 32'(rf_wr_en), 32'd0);
        tick();

        // Randomized traffic with held valid/ready payloads
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 99) < 3) begin
                idle_inputs();
                reset = 1'b1;
            end else begin
                reset = 1'b0;
                if (!(ex_vld && !m_gex)) begin
                    ex_vld  = ($urandom_range(0, 99) < 45);
                    ex_rd   = 5'($urandom_range(0, 31));
                    ex_data = $urandom;
                end
                if (!(lsu_vld && !m_glsu)) begin
                    lsu_vld  = (m_out > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3);
                    lsu_rd   = 5'($urandom_range(0, 31));
                    for (int t = 0; t < 10; t++) begin
                        if (!pend[lsu_rd]) lsu_rd = 5'($urandom_range(1, 31));
                    end
                    lsu_data = $urandom;
                end
                issue_vld = ($urandom_range(0, 99) < 40);
                issue_rd  = 5'($urandom_range(0, 31));
                if ($urandom_range(0, 99) < 95) begin
                    for (int t = 0; t < 10; t++) begin
                        if (pend[issue_rd]) issue_rd = 5'($urandom_range(0, 31));
                    end
                end
            end
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            applyStimulus();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
